// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle for imm_ext_pipe: upstream immediate channel and downstream
// extended-result channel. The slave modport is the extension unit's view.
interface imm_ext_pipe_if #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16
);
  logic              in_valid;
  logic              in_ready;
  logic [IN_W-1:0]   in_imm;
  logic [1:0]        in_mode;
  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_imm;
  logic              out_ovf;

  modport slave (
    input  in_valid, in_imm, in_mode, out_ready,
    output in_ready, out_valid, out_imm, out_ovf
  );

  modport master (
    output in_valid, in_imm, in_mode, out_ready,
    input  in_ready, out_valid, out_imm, out_ovf
  );
endinterface

// File: rtl/imm_ext_pipe.sv
// Pipelined immediate extension unit. Extends an IN_W-bit immediate to OUT_W
// bits (sign, zero, scaled-sign with overflow, upper placement) and holds
// results in a 2-entry registered skid buffer with valid/ready on both sides.
// The interface parameters must match IN_W/OUT_W of this module.
module imm_ext_pipe #(
  parameter int unsigned IN_W  = 8,
  parameter int unsigned OUT_W = 16,
  parameter int unsigned SHIFT = 1
) (
  input logic           clk,
  input logic           rst_n,
  imm_ext_pipe_if.slave bus
);

  localparam int unsigned WIDE_W = OUT_W + SHIFT;

  typedef enum logic [1:0] {StEmpty, StOne, StFull} state_e;

  state_e           state_q;
  logic             in_ready_q;
  logic             out_valid_q;
  logic [OUT_W-1:0] main_imm_q;
  logic             main_ovf_q;
  logic [OUT_W-1:0] skid_imm_q;
  logic             skid_ovf_q;

  logic [WIDE_W-1:0] wide_sext;
  logic [WIDE_W-1:0] wide_shl;
  logic [SHIFT:0]    top_bits;
  logic [OUT_W-1:0]  ext_imm;
  logic              ext_ovf;
  logic              in_fire;

  // Combinational extension of the presented immediate.
  always_comb begin
    wide_sext = {{(WIDE_W - IN_W){bus.in_imm[IN_W-1]}}, bus.in_imm};
    wide_shl  = wide_sext << SHIFT;
    // Discarded bits plus the kept MSB: all equal iff the scaled value fits.
    top_bits  = wide_shl[WIDE_W-1 -: SHIFT+1];
    ext_imm   = '0;
    ext_ovf   = 1'b0;
    case (bus.in_mode)
      2'b00: ext_imm = wide_sext[OUT_W-1:0];
      2'b01: ext_imm = OUT_W'(bus.in_imm);
      2'b10: begin
        ext_imm = wide_shl[OUT_W-1:0];
        ext_ovf = !((top_bits == '0) || (&top_bits));
      end
      default: ext_imm = OUT_W'(bus.in_imm) << (OUT_W - IN_W);
    endcase
  end

  assign in_fire = bus.in_valid & in_ready_q;

  // Skid-buffer FSM; main register feeds the output, skid holds the overflow entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StEmpty;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      main_imm_q  <= '0;
      main_ovf_q  <= 1'b0;
      skid_imm_q  <= '0;
      skid_ovf_q  <= 1'b0;
    end else begin
      case (state_q)
        StEmpty: begin
          if (in_fire) begin
            main_imm_q  <= ext_imm;
            main_ovf_q  <= ext_ovf;
            out_valid_q <= 1'b1;
            state_q     <= StOne;
          end
        end
        StOne: begin
          if (in_fire && bus.out_ready) begin
            main_imm_q <= ext_imm;
            main_ovf_q <= ext_ovf;
          end else if (in_fire) begin
            skid_imm_q <= ext_imm;
            skid_ovf_q <= ext_ovf;
            in_ready_q <= 1'b0;
            state_q    <= StFull;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StEmpty;
          end
        end
        StFull: begin
          if (bus.out_ready) begin
            main_imm_q <= skid_imm_q;
            main_ovf_q <= skid_ovf_q;
            in_ready_q <= 1'b1;
            state_q    <= StOne;
          end
        end
        default: begin
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
          state_q     <= StEmpty;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_imm   = main_imm_q;
  assign bus.out_ovf   = main_ovf_q;

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Self-checking bench for imm_ext_pipe: vector tables for the extension modes,
// hand-written backpressure and mid-operation reset sequences, and a random
// out_ready stream checked against a queue-based reference model.
module tb_imm_ext_pipe;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.IN_W(8), .OUT_W(16)) bus1 ();
  imm_ext_pipe_if #(.IN_W(8), .OUT_W(16)) bus9 ();

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .SHIFT(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  imm_ext_pipe #(.IN_W(8), .OUT_W(16), .SHIFT(9)) dut9 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus9)
  );

  typedef struct {
    logic [7:0]  imm;
    logic [1:0]  mode;
    logic [15:0] exp_imm;
    logic        exp_ovf;
  } vec_t;

  vec_t v1[10];
  vec_t v9[4];

  int n_checks = 0;
  int n_fail   = 0;

  logic [16:0] model_q[$];
  logic        stalled_prev;
  logic [16:0] held;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Arithmetic reference for the default (SHIFT=1) instance.
  function automatic logic [16:0] ref_ext(input logic [7:0] imm, input logic [1:0] mode);
    longint      v;
    logic [15:0] r;
    logic        o;
    o = 1'b0;
    v = longint'($signed(imm));
    case (mode)
      2'b00: r = v[15:0];
      2'b01: r = {8'h00, imm};
      2'b10: begin
        v = v * 2;
        r = v[15:0];
        o = (v > 32767) || (v < -32768);
      end
      default: r = {imm, 8'h00};
    endcase
    return {o, r};
  endfunction

  // One streaming cycle on bus1: drive at the negedge, sample 1 time unit later.
  task automatic stream_step(input bit valid, input bit ready);
    bus1.in_valid  = valid;
    bus1.in_imm    = 8'($urandom);
    bus1.in_mode   = 2'($urandom_range(0, 3));
    bus1.out_ready = ready;
    #1;
    check("stream_in_ready", bus1.in_ready, model_q.size() < 2);
    check("stream_out_valid", bus1.out_valid, model_q.size() != 0);
    if (stalled_prev) check("stream_stall_hold", {bus1.out_ovf, bus1.out_imm}, held);
    if (bus1.out_valid && model_q.size() != 0)
      check("stream_data", {bus1.out_ovf, bus1.out_imm}, model_q[0]);
    stalled_prev = bus1.out_valid && !bus1.out_ready;
    held         = {bus1.out_ovf, bus1.out_imm};
    if (bus1.out_valid && bus1.out_ready && model_q.size() != 0) void'(model_q.pop_front());
    if (bus1.in_valid && bus1.in_ready) model_q.push_back(ref_ext(bus1.in_imm, bus1.in_mode));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    v1[0] = '{8'h85, 2'b00, 16'hFF85, 1'b0};
    v1[1] = '{8'h85, 2'b01, 16'h0085, 1'b0};
    v1[2] = '{8'h85, 2'b10, 16'hFF0A, 1'b0};
    v1[3] = '{8'h85, 2'b11, 16'h8500, 1'b0};
    v1[4] = '{8'h7F, 2'b00, 16'h007F, 1'b0};
    v1[5] = '{8'h80, 2'b00, 16'hFF80, 1'b0};
    v1[6] = '{8'h00, 2'b00, 16'h0000, 1'b0};
    v1[7] = '{8'hFF, 2'b00, 16'hFFFF, 1'b0};
    v1[8] = '{8'hFF, 2'b01, 16'h00FF, 1'b0};
    v1[9] = '{8'h80, 2'b10, 16'hFF00, 1'b0};
    v9[0] = '{8'h40, 2'b10, 16'h8000, 1'b1};
    v9[1] = '{8'h3F, 2'b10, 16'h7E00, 1'b0};
    v9[2] = '{8'hC0, 2'b10, 16'h8000, 1'b0};
    v9[3] = '{8'hBF, 2'b10, 16'h7E00, 1'b1};

    bus1.in_valid = 1'b0; bus1.in_imm = '0; bus1.in_mode = '0; bus1.out_ready = 1'b1;
    bus9.in_valid = 1'b0; bus9.in_imm = '0; bus9.in_mode = '0; bus9.out_ready = 1'b1;
    stalled_prev = 1'b0;
    held = '0;

    // Asynchronous reset values.
    #1 rst_n = 1'b0;
    #2;
    check("rst_out_valid", bus1.out_valid, 1'b0);
    check("rst_in_ready", bus1.in_ready, 1'b1);
    check("rst_out_imm", bus1.out_imm, 16'h0000);
    check("rst_out_ovf", bus1.out_ovf, 1'b0);
    check("rst9_out_valid", bus9.out_valid, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Default instance: back-to-back vectors, one cycle latency.
    for (int i = 0; i < 10; i++) begin
      bus1.in_valid = 1'b1;
      bus1.in_imm   = v1[i].imm;
      bus1.in_mode  = v1[i].mode;
      @(negedge clk);
      check($sformatf("vec1_%0d_valid", i), bus1.out_valid, 1'b1);
      check($sformatf("vec1_%0d_imm", i), bus1.out_imm, v1[i].exp_imm);
      check($sformatf("vec1_%0d_ovf", i), bus1.out_ovf, v1[i].exp_ovf);
    end
    bus1.in_valid = 1'b0;
    @(negedge clk);
    check("vec1_drained", bus1.out_valid, 1'b0);

    // SHIFT=9 instance: scaled-mode overflow boundaries.
    for (int i = 0; i < 4; i++) begin
      bus9.in_valid = 1'b1;
      bus9.in_imm   = v9[i].imm;
      bus9.in_mode  = v9[i].mode;
      @(negedge clk);
      check($sformatf("vec9_%0d_valid", i), bus9.out_valid, 1'b1);
      check($sformatf("vec9_%0d_imm", i), bus9.out_imm, v9[i].exp_imm);
      check($sformatf("vec9_%0d_ovf", i), bus9.out_ovf, v9[i].exp_ovf);
    end
    bus9.in_valid = 1'b0;
    @(negedge clk);
    check("vec9_drained", bus9.out_valid, 1'b0);

    // Backpressure: two accepts fill the buffer, then drain in order.
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_mode   = 2'b00;
    bus1.in_imm    = 8'h01;
    @(negedge clk);
    check("bp_a_valid", bus1.out_valid, 1'b1);
    check("bp_a_in_ready", bus1.in_ready, 1'b1);
    check("bp_a_imm", bus1.out_imm, 16'h0001);
    bus1.in_imm = 8'h02;
    @(negedge clk);
    check("bp_full_in_ready", bus1.in_ready, 1'b0);
    check("bp_full_imm", bus1.out_imm, 16'h0001);
    bus1.in_valid = 1'b0;
    bus1.in_imm   = 8'hAA;
    @(negedge clk);
    check("bp_hold_in_ready", bus1.in_ready, 1'b0);
    check("bp_hold_imm", bus1.out_imm, 16'h0001);
    bus1.out_ready = 1'b1;
    @(negedge clk);
    check("bp_b_valid", bus1.out_valid, 1'b1);
    check("bp_b_imm", bus1.out_imm, 16'h0002);
    check("bp_b_in_ready", bus1.in_ready, 1'b1);
    @(negedge clk);
    check("bp_empty", bus1.out_valid, 1'b0);

    // Streaming with random backpressure, then bounded drain.
    for (int c = 0; c < 64; c++) stream_step(1'b1, 1'($urandom_range(0, 1)));
    for (int c = 0; c < 4; c++) stream_step(1'b0, 1'b1);
    check("stream_model_empty", model_q.size(), 0);
    check("stream_out_idle", bus1.out_valid, 1'b0);

    // Reset while FULL discards both entries.
    bus1.out_ready = 1'b0;
    bus1.in_valid  = 1'b1;
    bus1.in_mode   = 2'b00;
    bus1.in_imm    = 8'h11;
    @(negedge clk);
    bus1.in_imm = 8'h22;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("mr_full", bus1.in_ready, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("mr_out_valid", bus1.out_valid, 1'b0);
    check("mr_in_ready", bus1.in_ready, 1'b1);
    check("mr_out_imm", bus1.out_imm, 16'h0000);
    #1 rst_n = 1'b1;
    bus1.out_ready = 1'b1;
    @(negedge clk);
    check("mr_idle", bus1.out_valid, 1'b0);
    bus1.in_valid = 1'b1;
    bus1.in_mode  = 2'b01;
    bus1.in_imm   = 8'h33;
    @(negedge clk);
    bus1.in_valid = 1'b0;
    check("mr_first_valid", bus1.out_valid, 1'b1);
    check("mr_first_imm", bus1.out_imm, 16'h0033);
    @(negedge clk);
    check("mr_no_stale", bus1.out_valid, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
